t_state_generator: RTL and testbench

//  Generates the one-hot T-state vector ring_counter[9:0] that the controller/sequencer decodes.
//  - Advances one T-state per enabled clock.
//  - Wraps early according to the instruction length class.
//  - Freezes on HLT and supports single-step debug.
//  - Sits directly upstream of the controller/sequencer.
//  - Consumes the controller's enable_ring_counter and the instruction register output.

---
 rtl/t_state_generator_pkg.sv | 42 ++++
 rtl/t_state_generator_onehot_encoder10.sv | 20 ++
 rtl/t_state_generator.sv | 86 ++++++++
 tb/tb_t_state_generator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/t_state_generator_pkg.sv
// Shared opcode map and T-state class constants for the T-state generator and the controller.
// Also holds the halt-control state type and the instruction-length decode.
package t_state_generator_pkg;

  localparam int NUM_T    = 10;
  localparam int LAST_ONE = 5;
  localparam int LAST_TWO = 7;
  localparam int LAST_MEM = 9;

  localparam logic [NUM_T-1:0] RING_T0 = NUM_T'(1);

  localparam logic [7:0] OP_LDA       = 8'h00;
  localparam logic [7:0] OP_STA       = 8'h01;
  localparam logic [7:0] OP_ADD_B     = 8'h02;
  localparam logic [7:0] OP_ADD_C     = 8'h03;
  localparam logic [7:0] OP_SUB_B     = 8'h04;
  localparam logic [7:0] OP_SUB_C     = 8'h05;
  localparam logic [7:0] OP_JMP       = 8'h06;
  localparam logic [7:0] OP_JC        = 8'h07;
  localparam logic [7:0] OP_JZ        = 8'h08;
  localparam logic [7:0] OP_OUT       = 8'h09;
  localparam logic [7:0] OP_HLT       = 8'h0A;
  localparam logic [7:0] OP_MVI_ACCUM = 8'h0B;
  localparam logic [7:0] OP_MVI_B     = 8'h0C;
  localparam logic [7:0] OP_MVI_C     = 8'h0D;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Anything not explicitly listed, including X/Z opcodes, falls to the one-byte class.
  function automatic logic [3:0] last_t_state(input logic [7:0] op);
    case (op)
      OP_LDA, OP_STA:                            last_t_state = 4'(LAST_MEM);
      OP_JMP, OP_JC, OP_JZ,
      OP_MVI_ACCUM, OP_MVI_B, OP_MVI_C:          last_t_state = 4'(LAST_TWO);
      default:                                   last_t_state = 4'(LAST_ONE);
    endcase
  endfunction

endpackage

// File: rtl/t_state_generator_onehot_encoder10.sv
// 10-bit one-hot to binary index encoder.
// valid is high only when exactly one bit is set; index is meaningful only then.
module onehot_encoder10
  import t_state_generator_pkg::*;
(
  input  logic [NUM_T-1:0] onehot,
  output logic [3:0]       index,
  output logic             valid
);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_T; i++) begin
      if (onehot[i]) index = index | 4'(i);
    end
  end

  assign valid = (onehot != '0) && ((onehot & (onehot - NUM_T'(1))) == '0);

endmodule

// File: rtl/t_state_generator.sv
// One-hot T-state ring for the sequencer: early wrap by instruction class,
// HLT freeze, single-step, and recovery from a corrupted ring.
//
//  state   | meaning
//  ST_RUN  | ring advances on each enabled clock
//  ST_HALT | ring frozen (HLT at T4) until resume
module t_state_generator
  import t_state_generator_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       instruction,
  input  logic             enable_ring_counter,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             resume,
  output logic [NUM_T-1:0] ring_counter,
  output logic [3:0]       t_index,
  output logic             halted,
  output logic             instr_done,
  output logic             onehot_err
);

  run_state_e        state_q, state_d;
  logic [NUM_T-1:0]  ring_q, ring_d;
  logic              step_req_q;
  logic              onehot_err_d;
  logic              ring_valid;
  logic              step_pulse;
  logic              adv;
  logic              halt_req;
  logic              wrap;

  assign ring_counter = ring_q;

  onehot_encoder10 u_enc (
    .onehot (ring_counter),
    .index  (t_index),
    .valid  (ring_valid)
  );

  assign halted     = (state_q == ST_HALT);
  assign step_pulse = step_req & ~step_req_q;
  assign adv        = ~halted & (~step_mode | step_pulse);
  assign halt_req   = ~enable_ring_counter & ~halted;
  // T9 always closes the instruction, whatever the decode says.
  assign wrap       = (t_index == last_t_state(instruction)) | ring_counter[NUM_T-1];

  always_comb begin
    ring_d       = ring_q;
    state_d      = state_q;
    onehot_err_d = 1'b0;
    instr_done   = 1'b0;
    if (!ring_valid) begin
      ring_d       = RING_T0;
      onehot_err_d = 1'b1;
    end else if (resume) begin
      ring_d  = RING_T0;
      state_d = ST_RUN;
    end else if (halt_req) begin
      state_d = ST_HALT;
    end else if (adv) begin
      if (wrap) begin
        ring_d     = RING_T0;
        instr_done = 1'b1;
      end else begin
        ring_d = {ring_counter[NUM_T-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q     <= RING_T0;
      state_q    <= ST_RUN;
      step_req_q <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      ring_q     <= ring_d;
      state_q    <= state_d;
      step_req_q <= step_req;
      onehot_err <= onehot_err_d;
    end
  end

endmodule

// File: tb/tb_t_state_generator.sv
// Directed bench for t_state_generator with a per-cycle reference model and
// an expected-result queue compared against the DUT outputs.
module tb_t_state_generator;

  typedef struct packed {
    logic [9:0] ring;
    logic [3:0] t;
    logic       halted;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instruction;
  logic       enable_ring_counter;
  logic       step_mode;
  logic       step_req;
  logic       resume;
  logic [9:0] ring_counter;
  logic [3:0] t_index;
  logic       halted;
  logic       instr_done;
  logic       onehot_err;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  int m_t;
  bit m_halt, m_sq, m_err;

  t_state_generator dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction         (instruction),
    .enable_ring_counter (enable_ring_counter),
    .step_mode           (step_mode),
    .step_req            (step_req),
    .resume              (resume),
    .ring_counter        (ring_counter),
    .t_index             (t_index),
    .halted              (halted),
    .instr_done          (instr_done),
    .onehot_err          (onehot_err)
  );

  always #5 clk = ~clk;

  function automatic int exp_last(input logic [7:0] op);
    if (op === 8'h00 || op === 8'h01) return 9;
    if (op === 8'h06 || op === 8'h07 || op === 8'h08 ||
        op === 8'h0B || op === 8'h0C || op === 8'h0D) return 7;
    return 5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("ring", 32'(ring_counter), 32'(e.ring));
      check("t_index", 32'(t_index), 32'(e.t));
      check("halted", 32'(halted), 32'(e.halted));
      check("instr_done", 32'(instr_done), 32'(e.done));
      check("onehot_err", 32'(onehot_err), 32'(e.err));
    end
  endtask

  // One clock: predict this cycle's outputs, compare, advance the model, cross the edge.
  task automatic cycle();
    exp_t e;
    int   last;
    bit   adv, hreq, wrap, done;
    #1;
    last = exp_last(instruction);
    adv  = !m_halt && (!step_mode || (step_req && !m_sq));
    hreq = !enable_ring_counter && !m_halt;
    wrap = (m_t == last) || (m_t == 9);
    done = !resume && !hreq && adv && wrap;
    e.ring   = 10'(1 << m_t);
    e.t      = 4'(m_t);
    e.halted = m_halt;
    e.done   = done;
    e.err    = m_err;
    sb.push_back(e);
    compare_outputs();
    if (resume) begin
      m_t = 0; m_halt = 0;
    end else if (hreq) begin
      m_halt = 1;
    end else if (adv) begin
      m_t = wrap ? 0 : m_t + 1;
    end
    m_err = 0;
    m_sq  = step_req;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int t);
    for (int k = 0; k < 40 && m_t != t; k++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    instruction = 8'h02;
    enable_ring_counter = 1'b1;
    step_mode = 1'b0;
    step_req = 1'b0;
    resume = 1'b0;
    m_t = 0; m_halt = 0; m_sq = 0; m_err = 0;
    #12;
    check("rst_ring", 32'(ring_counter), 32'h001);
    check("rst_tidx", 32'(t_index), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_err", 32'(onehot_err), 32'h0);
    rst = 1'b0;

    // ADD_B: six-clock period, done at T5
    run(12);
    // LDA: ten-clock period; MVI_B: eight; undefined opcode: six
    instruction = 8'h00; run(20);
    instruction = 8'h0C; run(16);
    instruction = 8'hFF; run(12);

    // opcode swapped late: past the short class's last state, so T9 must close it
    instruction = 8'h00; run_to(6);
    instruction = 8'h02; run(6);

    // asynchronous reset mid-T6
    instruction = 8'h00; run_to(6);
    check("t6_reached", 32'(t_index), 32'h6);
    #3 rst = 1'b1;
    #1;
    check("async_rst_ring", 32'(ring_counter), 32'h001);
    check("async_rst_halted", 32'(halted), 32'h0);
    #1 rst = 1'b0;
    m_t = 0; m_halt = 0; m_sq = 0; m_err = 0;
    run(3);

    // HLT at T4, then resume
    instruction = 8'h0A; run_to(4);
    enable_ring_counter = 1'b0; run(4);
    check("hlt_hold", 32'(ring_counter), 32'h010);
    resume = 1'b1; enable_ring_counter = 1'b1; cycle();
    resume = 1'b0; run(3);

    // single step: level held five clocks, then three toggles
    instruction = 8'h00;
    step_mode = 1'b1; step_req = 1'b1; run(5);
    step_req = 1'b0; cycle();
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1; cycle();
      step_req = 1'b0; cycle();
    end
    step_mode = 1'b0; run(4);

    // corrupted ring is recovered to T0 with a one-cycle error pulse
    force dut.ring_counter = 10'h006;
    @(posedge clk);
    #1;
    release dut.ring_counter;
    #1;
    check("recover_ring", 32'(ring_counter), 32'h001);
    check("recover_err", 32'(onehot_err), 32'h1);
    m_t = 0; m_err = 1; m_sq = step_req;
    instruction = 8'h02;
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
